// File: rtl/edge_event_monitor.sv
// Multi-channel edge monitor: per-channel rise/fall/both detection with pulse, saturating count,
// sticky/sat flags and first-event capture. Optional interrupt output behind EDGE_MON_IRQ_EN.
module edge_event_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       sig_in,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic                    clr,
`ifdef EDGE_MON_IRQ_EN
    input  logic [NUM_CH-1:0]       irq_mask,
    output logic                    irq,
`endif
    output logic [NUM_CH-1:0]       edge_pulse,
    output logic [NUM_CH-1:0]       sticky,
    output logic [NUM_CH-1:0]       sat,
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic                    first_vld,
    output logic [IDX_W-1:0]        first_ch
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0]       sig_q, sig_d;
    logic                    primed_q, primed_d;
    logic [NUM_CH-1:0]       edge_pulse_q, edge_pulse_d;
    logic [NUM_CH-1:0]       sticky_q, sticky_d;
    logic [NUM_CH-1:0]       sat_q, sat_d;
    logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
    logic                    first_vld_q, first_vld_d;
    logic [IDX_W-1:0]        first_ch_q, first_ch_d;
    logic [NUM_CH-1:0]       det;
`ifdef EDGE_MON_IRQ_EN
    logic                    irq_q, irq_d;
`endif

    always_comb begin
        sig_d       = sig_in;
        primed_d    = 1'b1;
        det         = '0;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        first_vld_d = first_vld_q;
        first_ch_d  = first_ch_q;

        // mode bit 2i enables rising edges, bit 2i+1 enables falling edges
        for (int i = 0; i < NUM_CH; i++) begin
            det[i] = primed_q &
                     ((mode[2*i]   &  sig_in[i] & ~sig_q[i]) |
                      (mode[2*i+1] & ~sig_in[i] &  sig_q[i]));
        end

        edge_pulse_d = det;
        sticky_d     = sticky_q | det;

        for (int i = 0; i < NUM_CH; i++) begin
            if (det[i]) begin
                if (cnt_q[i*CNT_W +: CNT_W] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end

        // Descending scan so the lowest firing index is the one left standing
        if (!first_vld_q && (|det)) begin
            first_vld_d = 1'b1;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (det[i]) begin
                    first_ch_d = IDX_W'(i);
                end
            end
        end

        // clr wins over a coincident event; edge_pulse is intentionally left alone
        if (clr) begin
            sticky_d    = '0;
            sat_d       = '0;
            cnt_d       = '0;
            first_vld_d = 1'b0;
            first_ch_d  = '0;
        end

`ifdef EDGE_MON_IRQ_EN
        irq_d = |(sticky_d & irq_mask);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q        <= '0;
            primed_q     <= 1'b0;
            edge_pulse_q <= '0;
            sticky_q     <= '0;
            sat_q        <= '0;
            cnt_q        <= '0;
            first_vld_q  <= 1'b0;
            first_ch_q   <= '0;
        end else begin
            sig_q        <= sig_d;
            primed_q     <= primed_d;
            edge_pulse_q <= edge_pulse_d;
            sticky_q     <= sticky_d;
            sat_q        <= sat_d;
            cnt_q        <= cnt_d;
            first_vld_q  <= first_vld_d;
            first_ch_q   <= first_ch_d;
        end
    end

`ifdef EDGE_MON_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign edge_pulse = edge_pulse_q;
    assign sticky     = sticky_q;
    assign sat        = sat_q;
    assign cnt        = cnt_q;
    assign first_vld  = first_vld_q;
    assign first_ch   = first_ch_q;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Scoreboard bench for edge_event_monitor (NUM_CH=4, CNT_W=4); covers the irq output when
// EDGE_MON_IRQ_EN is defined.
module tb_edge_event_monitor;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef EDGE_MON_IRQ_EN
    localparam int OBS_W  = 3*NUM_CH + NUM_CH*CNT_W + 1 + IDX_W + 1;
`else
    localparam int OBS_W  = 3*NUM_CH + NUM_CH*CNT_W + 1 + IDX_W;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       sig_in;
    logic [2*NUM_CH-1:0]     mode;
    logic                    clr;
    logic [NUM_CH-1:0]       irq_mask = '0;
    logic                    irq;
    logic [NUM_CH-1:0]       edge_pulse, sticky, sat;
    logic [NUM_CH*CNT_W-1:0] cnt;
    logic                    first_vld;
    logic [IDX_W-1:0]        first_ch;

    edge_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .mode       (mode),
        .clr        (clr),
`ifdef EDGE_MON_IRQ_EN
        .irq_mask   (irq_mask),
        .irq        (irq),
`endif
        .edge_pulse (edge_pulse),
        .sticky     (sticky),
        .sat        (sat),
        .cnt        (cnt),
        .first_vld  (first_vld),
        .first_ch   (first_ch)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] act_q[$];

    // Reference model state
    logic [NUM_CH-1:0] m_sig_q, m_pulse, m_sticky, m_sat;
    logic              m_primed, m_fv, m_irq;
    logic [IDX_W-1:0]  m_fch;
    int                m_cnt[NUM_CH];

    function automatic void model_reset();
        m_sig_q = '0; m_pulse = '0; m_sticky = '0; m_sat = '0;
        m_primed = 1'b0; m_fv = 1'b0; m_irq = 1'b0; m_fch = '0;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    endfunction

    function automatic void model_step(input logic [NUM_CH-1:0] s, input logic [2*NUM_CH-1:0] md,
                                       input logic c);
        logic [NUM_CH-1:0] d;
        logic found;
        for (int i = 0; i < NUM_CH; i++) begin
            d[i] = m_primed && ((md[2*i] && s[i] && !m_sig_q[i]) ||
                                (md[2*i+1] && !s[i] && m_sig_q[i]));
        end
        m_pulse = d;
        if (c) begin
            m_sticky = '0; m_sat = '0; m_fv = 1'b0; m_fch = '0;
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        end else begin
            found = m_fv;
            for (int i = 0; i < NUM_CH; i++) begin
                if (d[i]) begin
                    m_sticky[i] = 1'b1;
                    if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
                    else m_sat[i] = 1'b1;
                    if (!found) begin
                        found = 1'b1; m_fv = 1'b1; m_fch = IDX_W'(i);
                    end
                end
            end
        end
        m_irq    = |(m_sticky & irq_mask);
        m_sig_q  = s;
        m_primed = 1'b1;
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        logic [NUM_CH*CNT_W-1:0] cf;
        for (int i = 0; i < NUM_CH; i++) cf[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`ifdef EDGE_MON_IRQ_EN
        return {m_pulse, m_sticky, m_sat, cf, m_fv, m_fch, m_irq};
`else
        return {m_pulse, m_sticky, m_sat, cf, m_fv, m_fch};
`endif
    endfunction

    function automatic logic [OBS_W-1:0] dut_obs();
`ifdef EDGE_MON_IRQ_EN
        return {edge_pulse, sticky, sat, cnt, first_vld, first_ch, irq};
`else
        return {edge_pulse, sticky, sat, cnt, first_vld, first_ch};
`endif
    endfunction

    // One clock of stimulus: inputs change at negedge, outputs captured 1ns after posedge
    task automatic drive(input logic [NUM_CH-1:0] s, input logic [2*NUM_CH-1:0] md, input logic c);
        @(negedge clk);
        rst = 1'b1; sig_in = s; mode = md; clr = c;
        model_step(s, md, c);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        act_q.push_back(dut_obs());
    endtask

    task automatic test_reset();
        logic [OBS_W-1:0] e, a;
        rst = 1'b0; sig_in = 4'b1111; mode = 8'hFF; clr = 1'b0;
        model_reset();
        #3;
        n_vec++;
        if (dut_obs() !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", dut_obs());
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (dut_obs() !== '0) begin
            n_err++; $display("FAIL reset_held: got %h expected 0", dut_obs());
        end
        drive(4'b1111, 8'hFF, 1'b0);
        n_vec++;
        if (edge_pulse !== 4'b0000) begin
            n_err++; $display("FAIL prime_no_pulse: got %b expected 0000", edge_pulse);
        end
        drive(4'b0000, 8'hFF, 1'b0);
        n_vec++;
        if (edge_pulse !== 4'b1111 || cnt !== 16'h1111 || first_vld !== 1'b1 || first_ch !== 2'd0) begin
            n_err++;
            $display("FAIL first_fall: pulse %b cnt %h fv %b fch %0d expected 1111 1111 1 0",
                     edge_pulse, cnt, first_vld, first_ch);
        end
        drive(4'b0000, 8'hFF, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL reset_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_mode();
        logic [OBS_W-1:0] e, a;
        logic [7:0] md;
        md = 8'b00_10_01_00;
        drive(4'b0000, md, 1'b1);
        drive(4'b0110, md, 1'b0);
        n_vec++;
        if (edge_pulse !== 4'b0010) begin
            n_err++; $display("FAIL mode_rise: got %b expected 0010", edge_pulse);
        end
        drive(4'b0000, md, 1'b0);
        n_vec++;
        if (edge_pulse !== 4'b0100) begin
            n_err++; $display("FAIL mode_fall: got %b expected 0100", edge_pulse);
        end
        n_vec++;
        if (sticky !== 4'b0110 || cnt !== 16'h0110) begin
            n_err++; $display("FAIL mode_counts: sticky %b cnt %h expected 0110 0110", sticky, cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL mode_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_saturation();
        logic [OBS_W-1:0] e, a;
        int pulses;
        pulses = 0;
        drive(4'b0000, 8'h03, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            drive({3'b000, 1'(k % 2)}, 8'h03, 1'b0);
            if (edge_pulse[0]) pulses++;
            if (k == 15) begin
                n_vec++;
                if (sat[0] !== 1'b0 || cnt[3:0] !== 4'd15) begin
                    n_err++; $display("FAIL sat_at15: sat %b cnt %0d expected 0 15", sat[0], cnt[3:0]);
                end
            end
            if (k == 16) begin
                n_vec++;
                if (sat[0] !== 1'b1) begin
                    n_err++; $display("FAIL sat_at16: got %b expected 1", sat[0]);
                end
            end
        end
        n_vec++;
        if (pulses != 20 || cnt[3:0] !== 4'd15) begin
            n_err++; $display("FAIL sat_hold: pulses %0d cnt %0d expected 20 15", pulses, cnt[3:0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL sat_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_clr_edge();
        logic [OBS_W-1:0] e, a;
        logic [7:0] md;
        md = 8'b00_11_00_00;
        drive(4'b0000, md, 1'b1);
        drive(4'b0100, md, 1'b0);
        drive(4'b0000, md, 1'b0);
        drive(4'b0100, md, 1'b0);
        n_vec++;
        if (cnt[11:8] !== 4'd3 || sticky[2] !== 1'b1) begin
            n_err++; $display("FAIL clr_setup: cnt2 %0d sticky2 %b expected 3 1", cnt[11:8], sticky[2]);
        end
        drive(4'b0000, md, 1'b1);
        n_vec++;
        if (edge_pulse[2] !== 1'b1 || cnt !== '0 || sticky !== '0 || sat !== '0 || first_vld !== 1'b0) begin
            n_err++;
            $display("FAIL clr_coincident: pulse2 %b cnt %h sticky %b sat %b fv %b expected 1 0 0 0 0",
                     edge_pulse[2], cnt, sticky, sat, first_vld);
        end
        drive(4'b0100, md, 1'b0);
        n_vec++;
        if (cnt[11:8] !== 4'd1 || first_vld !== 1'b1 || first_ch !== 2'd2) begin
            n_err++; $display("FAIL clr_after: cnt2 %0d fv %b fch %0d expected 1 1 2",
                              cnt[11:8], first_vld, first_ch);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL clr_sb: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [OBS_W-1:0] e, a;
        drive(4'b0000, 8'h03, 1'b1);
        for (int k = 1; k <= 7; k++) drive({3'b000, 1'(k % 2)}, 8'h03, 1'b0);
        n_vec++;
        if (cnt[3:0] !== 4'd7) begin
            n_err++; $display("FAIL mid_setup: cnt0 %0d expected 7", cnt[3:0]);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (dut_obs() !== '0) begin
            n_err++; $display("FAIL mid_async: got %h expected 0", dut_obs());
        end
        drive(4'b0001, 8'h03, 1'b0);
        n_vec++;
        if (edge_pulse !== 4'b0000 || cnt !== '0) begin
            n_err++; $display("FAIL mid_prime: pulse %b cnt %h expected 0000 0", edge_pulse, cnt);
        end
        drive(4'b0000, 8'h03, 1'b0);
        n_vec++;
        if (edge_pulse !== 4'b0001 || cnt[3:0] !== 4'd1) begin
            n_err++; $display("FAIL mid_count: pulse %b cnt0 %0d expected 0001 1", edge_pulse, cnt[3:0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL mid_sb: got %h expected %h", a, e); end
        end
    endtask

`ifdef EDGE_MON_IRQ_EN
    task automatic test_irq();
        logic [OBS_W-1:0] e, a;
        irq_mask = 4'b0100;
        drive(4'b0000, 8'hFF, 1'b1);
        drive(4'b0001, 8'hFF, 1'b0);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b expected 0", irq); end
        drive(4'b0101, 8'hFF, 1'b0);
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq); end
        drive(4'b0101, 8'hFF, 1'b1);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clr: got %b expected 0", irq); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL irq_sb: got %h expected %h", a, e); end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [OBS_W-1:0] e, a;
        for (int k = 0; k < 300; k++) begin
            irq_mask = 4'($urandom_range(0, 15));
            drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL random_sb: got %h expected %h", a, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode();
        test_saturation();
        test_clr_edge();
        test_reset_mid();
`ifdef EDGE_MON_IRQ_EN
        test_irq();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
